// File: rtl/bp_me_wormhole_packet_serialize_lce_req.sv
// ----------------------------------------------------------------------------
// bp_me_wormhole_packet_serialize_lce_req
//
// Purpose:
//   Takes one encoded LCE request wormhole packet {payload, cid, len, cord}
//   and sends it onto a coherence NoC link as len+1 flits, flit 0 first.
//   The block holds exactly one packet. It sits between the LCE request
//   packet encoder and a wormhole router/concentrator input port.
//
// Ports:
//   clk_i               clock, rising edge
//   reset_i             asynchronous active-high reset
//   packet_i            {payload, cid, len, cord}, cord in the LSBs
//   packet_v_i          packet_i valid
//   packet_ready_and_o  packet accepted on packet_v_i & packet_ready_and_o
//   link_data_o         current flit
//   link_v_o            link_data_o valid
//   link_ready_and_i    flit consumed on link_v_o & link_ready_and_i
//   protocol_error_o    sticky flag: a packet with len >= max flits was accepted
// ----------------------------------------------------------------------------
module bp_me_wormhole_packet_serialize_lce_req #(
  parameter int flit_width_p    = 64,
  parameter int cord_width_p    = 4,
  parameter int len_width_p     = 3,
  parameter int cid_width_p     = 2,
  parameter int payload_width_p = 246,
  localparam int packet_width_lp = payload_width_p + cid_width_p + len_width_p + cord_width_p
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [packet_width_lp-1:0] packet_i,
  input  logic                       packet_v_i,
  output logic                       packet_ready_and_o,
  output logic [flit_width_p-1:0]    link_data_o,
  output logic                       link_v_o,
  input  logic                       link_ready_and_i,
  output logic                       protocol_error_o
);

  localparam int max_flits_lp   = (packet_width_lp + flit_width_p - 1) / flit_width_p;
  localparam int shift_width_lp = max_flits_lp * flit_width_p;
  localparam logic [len_width_p-1:0] c_lastIdx = len_width_p'(max_flits_lp - 1);

  // The counter must be able to hold the index of the last physical flit.
  generate
    if (len_width_p < $clog2(max_flits_lp)) begin : g_lenWidthCheck
      $error("len_width_p too narrow to index every flit of the packet");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                    r_state;
  logic [shift_width_lp-1:0] r_shift;
  logic [len_width_p-1:0]    r_cnt;
  logic                      r_err;

  logic [len_width_p-1:0] w_len;
  logic                   w_tooLong;
  logic                   w_accept;
  logic                   w_linkHs;

  assign w_len     = packet_i[cord_width_p +: len_width_p];
  assign w_tooLong = (w_len > c_lastIdx);
  assign w_accept  = packet_v_i & packet_ready_and_o;
  assign w_linkHs  = link_v_o & link_ready_and_i;

  // Ready is gated by reset directly so nothing is accepted while reset is held.
  assign packet_ready_and_o = (r_state == IDLE) & ~reset_i;
  assign link_v_o           = (r_state == SEND);
  // In IDLE the low slice still holds the last flit sent, since the final
  // handshake does not shift; after reset it reads zero.
  assign link_data_o        = r_shift[flit_width_p-1:0];
  assign protocol_error_o   = r_err;

  // Packet load, flit shifting and length counting. An oversized len is
  // clamped to the last physical flit and flagged; flits beyond len are
  // never shifted out, so a short packet drops its trailing bits.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift <= shift_width_lp'(packet_i);
            r_cnt   <= w_tooLong ? c_lastIdx : w_len;
            r_err   <= r_err | w_tooLong;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_linkHs) begin
            if (r_cnt != '0) begin
              r_shift <= r_shift >> flit_width_p;
              r_cnt   <= r_cnt - 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_me_wormhole_packet_serialize_lce_req.sv
// ----------------------------------------------------------------------------
// tb_bp_me_wormhole_packet_serialize_lce_req
//
// Directed bench for the LCE request serializer. A queue-based model of the
// flits still owed on the link is compared against the DUT every cycle, and
// a few hand-computed expectations pin specific flits and flags.
// ----------------------------------------------------------------------------
module tb_bp_me_wormhole_packet_serialize_lce_req;

  localparam int FW = 64;
  localparam int PW = 255;
  localparam int MF = 4;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [PW-1:0] packet_i;
  logic          packet_v_i;
  logic          packet_ready_and_o;
  logic [FW-1:0] link_data_o;
  logic          link_v_o;
  logic          link_ready_and_i;
  logic          protocol_error_o;

  int total = 0;
  int bad   = 0;

  bp_me_wormhole_packet_serialize_lce_req dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .packet_i           (packet_i),
    .packet_v_i         (packet_v_i),
    .packet_ready_and_o (packet_ready_and_o),
    .link_data_o        (link_data_o),
    .link_v_o           (link_v_o),
    .link_ready_and_i   (link_ready_and_i),
    .protocol_error_o   (protocol_error_o)
  );

  always #5 clk_i = ~clk_i;

  // One comparison: counts, and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of flits still owed on the link. An accepted packet owes
  // min(len,MF-1)+1 flits taken from its zero-padded image; a link handshake
  // retires the front flit. The block is ready exactly when nothing is owed.
  logic [FW-1:0] expQ[$];
  logic [FW-1:0] lastData;
  logic          expErr;

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      expQ.delete();
      lastData = '0;
      expErr   = 1'b0;
    end else if (expQ.size() != 0) begin
      if (link_ready_and_i) lastData = expQ.pop_front();
    end else if (packet_v_i) begin
      logic [MF*FW-1:0] img;
      int               len;
      int               n;
      img = {1'b0, packet_i};
      len = int'(packet_i[6:4]);
      n   = (len > MF - 1) ? MF : len + 1;
      if (len > MF - 1) expErr = 1'b1;
      for (int k = 0; k < n; k++) expQ.push_back(img[k*FW +: FW]);
    end
  end

  // Every-cycle compare, one time step after the rising edge.
  always @(posedge clk_i) begin
    #1;
    checkOutput("link_v", {63'd0, link_v_o}, {63'd0, expQ.size() != 0});
    checkOutput("ready", {63'd0, packet_ready_and_o}, {63'd0, (expQ.size() == 0) && !reset_i});
    checkOutput("data", link_data_o, (expQ.size() != 0) ? expQ[0] : lastData);
    checkOutput("perr", {63'd0, protocol_error_o}, {63'd0, expErr});
  end

  // Record every flit that actually moves on the link (pre-edge values).
  logic [FW-1:0] capFlits[$];
  always @(posedge clk_i) begin
    if (!reset_i && link_v_o && link_ready_and_i) capFlits.push_back(link_data_o);
  end

  function automatic logic [PW-1:0] mkPkt(input logic [2:0] len, input logic [15:0] seed);
    logic [MF*FW-1:0] img;
    for (int i = 0; i < 8; i++) img[i*32 +: 32] = {seed, 16'(i * 16'h1111 + 16'h0F0F)};
    img[6:4] = len;
    return img[PW-1:0];
  endfunction

  // Present a packet until accepted (bounded), then drop valid.
  task automatic applyStimulus(input logic [PW-1:0] p);
    int waited = 0;
    @(negedge clk_i);
    packet_i   = p;
    packet_v_i = 1'b1;
    while (!packet_ready_and_o && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    if (!packet_ready_and_o) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: ready=%b required 1", packet_ready_and_o);
    end
    @(negedge clk_i);
    packet_v_i = 1'b0;
  endtask

  // Wait (bounded) until the given number of flits have been captured.
  task automatic waitFlits(input int n);
    int waited = 0;
    while (capFlits.size() < n && waited < 100) begin
      @(negedge clk_i);
      waited++;
    end
    if (capFlits.size() < n) begin
      total++;
      bad++;
      $display("[TB] FAIL flit_timeout: got %0d flits required %0d", capFlits.size(), n);
    end
  endtask

  logic [PW-1:0] pkt;
  logic [FW-1:0] held;

  initial begin
    // 1. Reset with packet_v_i high.
    reset_i          = 1'b1;
    packet_v_i       = 1'b1;
    packet_i         = mkPkt(3'd0, 16'hDEAD);
    link_ready_and_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_link_v", {63'd0, link_v_o}, 64'd0);
    checkOutput("rst_ready", {63'd0, packet_ready_and_o}, 64'd0);
    checkOutput("rst_data", link_data_o, 64'd0);
    reset_i    = 1'b0;
    packet_v_i = 1'b0;
    #1;
    checkOutput("post_rst_ready", {63'd0, packet_ready_and_o}, 64'd1);
    checkOutput("post_rst_perr", {63'd0, protocol_error_o}, 64'd0);

    // 2. Single-flit packet.
    capFlits.delete();
    pkt = mkPkt(3'd0, 16'hA001);
    applyStimulus(pkt);
    waitFlits(1);
    repeat (3) @(negedge clk_i);
    checkOutput("len0_count", 64'(capFlits.size()), 64'd1);
    checkOutput("len0_flit0", capFlits[0], {16'hA001, 16'h0F0F + 16'h1111, 16'hA001, 16'h0F0F} & ~64'h70 | 64'h00);

    // 3. Four flits, link always ready; last flit padded with a zero MSB.
    capFlits.delete();
    pkt = mkPkt(3'd3, 16'hB002);
    applyStimulus(pkt);
    waitFlits(4);
    repeat (3) @(negedge clk_i);
    checkOutput("len3_count", 64'(capFlits.size()), 64'd4);
    checkOutput("len3_flit0", capFlits[0], pkt[63:0]);
    checkOutput("len3_flit1", capFlits[1], pkt[127:64]);
    checkOutput("len3_flit2", capFlits[2], pkt[191:128]);
    checkOutput("len3_flit3", capFlits[3], {1'b0, pkt[254:192]});
    checkOutput("len3_flit3_top", {63'd0, capFlits[3][63]}, 64'd0);

    // 4. Backpressure on flit 0 for three cycles.
    capFlits.delete();
    link_ready_and_i = 1'b0;
    pkt = mkPkt(3'd1, 16'hC003);
    applyStimulus(pkt);
    held = pkt[63:0];
    for (int c = 0; c < 3; c++) begin
      checkOutput("stall_v", {63'd0, link_v_o}, 64'd1);
      checkOutput("stall_data", link_data_o, held);
      checkOutput("stall_ready", {63'd0, packet_ready_and_o}, 64'd0);
      @(negedge clk_i);
    end
    link_ready_and_i = 1'b1;
    waitFlits(2);
    repeat (3) @(negedge clk_i);
    checkOutput("len1_count", 64'(capFlits.size()), 64'd2);
    checkOutput("len1_flit1", capFlits[1], pkt[127:64]);

    // 5. Oversized len: clamped to four flits, sticky error.
    capFlits.delete();
    pkt = mkPkt(3'd6, 16'hD004);
    applyStimulus(pkt);
    waitFlits(4);
    repeat (4) @(negedge clk_i);
    checkOutput("len6_count", 64'(capFlits.size()), 64'd4);
    checkOutput("len6_perr", {63'd0, protocol_error_o}, 64'd1);
    pkt = mkPkt(3'd1, 16'hD005);
    applyStimulus(pkt);
    repeat (5) @(negedge clk_i);
    checkOutput("perr_sticky", {63'd0, protocol_error_o}, 64'd1);

    // 6. Reset mid-packet after flit 1, then a fresh len=2 packet.
    capFlits.delete();
    pkt = mkPkt(3'd3, 16'hE006);
    applyStimulus(pkt);
    waitFlits(2);
    reset_i = 1'b1;
    #1;
    checkOutput("midrst_link_v", {63'd0, link_v_o}, 64'd0);
    checkOutput("midrst_perr", {63'd0, protocol_error_o}, 64'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    capFlits.delete();
    pkt = mkPkt(3'd2, 16'hF007);
    applyStimulus(pkt);
    waitFlits(3);
    repeat (3) @(negedge clk_i);
    checkOutput("after_rst_count", 64'(capFlits.size()), 64'd3);
    checkOutput("after_rst_flit0", capFlits[0], pkt[63:0]);
    checkOutput("after_rst_flit2", capFlits[2], pkt[191:128]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
